// File: rtl/keypad_event_queue_if.sv
// Event-FIFO read port: head entry plus valid/ready handshake.
interface keypad_event_queue_if #(
    parameter int KW = 4
);
    logic          out_valid;
    logic          out_ready;
    logic [KW-1:0] out_code;
    logic          out_rel;

    modport master (output out_valid, out_code, out_rel, input out_ready);
    modport slave  (input out_valid, out_code, out_rel, output out_ready);
endinterface

// File: rtl/keypad_event_queue.sv
// Keypad matrix scanner with per-key frame debounce and a press/release event FIFO.
// One debounce lane per key; lanes are instantiated as an array over the matrix.
module keypad_key_deb #(
    parameter int DEB_FRAMES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    input  logic raw,
    input  logic clr_pend,
    output logic state,
    output logic pend
);
    localparam int CNW = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
    localparam logic [CNW-1:0] LAST = CNW'(DEB_FRAMES - 1);

    logic [CNW-1:0] cnt;

    // Pending is only cleared in the emit window, which never overlaps a sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 1'b0;
            cnt   <= '0;
            pend  <= 1'b0;
        end else if (sample) begin
            if (raw == state) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                state <= raw;
                cnt   <= '0;
                pend  <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (clr_pend) begin
            pend <= 1'b0;
        end
    end
endmodule

module keypad_event_queue #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_FRAMES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int REPORT_REL = 1
) (
    input  logic                               clk,
    input  logic                               RST,
    input  logic [COLS-1:0]                    col,
    output logic [ROWS-1:0]                    row,
    keypad_event_queue_if.master               ev,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               overflow,
    input  logic                               clr_ovf,
    output logic                               light
);
    localparam int NK = ROWS * COLS;
    localparam int KW = $clog2(NK);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic          rel;
        logic [KW-1:0] code;
    } ev_t;

    logic [SW-1:0]   slot_cnt;
    logic [RW-1:0]   row_idx, row_idx_nxt, emit_row;
    logic            slot_end;
    logic [NK-1:0]   key_state, key_pend, clr_pend;
    logic [KW-1:0]   emit_key;
    logic            emit_hit, push, pop, full, wr_en;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    ev_t             mem [FIFO_DEPTH];

    assign slot_end    = (slot_cnt == SW'(SCAN_DIV - 1));
    assign row_idx_nxt = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;

    // emit_row remembers which row was just sampled so its keys can be
    // examined column by column during the first COLS cycles of the next slot.
    always_ff @(posedge clk) begin
        if (RST) begin
            slot_cnt <= '0;
            row_idx  <= '0;
            emit_row <= '0;
            row      <= ~ROWS'(1);
        end else if (slot_end) begin
            slot_cnt <= '0;
            emit_row <= row_idx;
            row_idx  <= row_idx_nxt;
            row      <= ~(ROWS'(1) << row_idx_nxt);
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            keypad_key_deb #(.DEB_FRAMES(DEB_FRAMES)) u_key (
                .clk      (clk),
                .rst      (RST),
                .sample   (slot_end && (row_idx == RW'(r))),
                .raw      (~col[c]),
                .clr_pend (clr_pend[r*COLS+c]),
                .state    (key_state[r*COLS+c]),
                .pend     (key_pend[r*COLS+c])
            );
        end
    end

    always_comb begin
        emit_key = KW'(int'(emit_row) * COLS + int'(slot_cnt));
        emit_hit = (int'(slot_cnt) < COLS) && key_pend[emit_key];
        clr_pend = '0;
        if (emit_hit) clr_pend[emit_key] = 1'b1;
        // Releases are consumed silently when only presses are reported.
        push = emit_hit && ((REPORT_REL != 0) || key_state[emit_key]);
    end

    assign ev.out_valid = (count != '0);
    assign ev.out_code  = mem[rd_ptr].code;
    assign ev.out_rel   = mem[rd_ptr].rel;

    assign pop   = ev.out_valid && ev.out_ready;
    assign full  = (count == CW'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the slot the push lands in.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            light    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{rel: ~key_state[emit_key], code: emit_key};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !wr_en) overflow <= 1'b1;
            else if (clr_ovf)   overflow <= 1'b0;
            light <= |key_state;
        end
    end
endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench: two instances (release reporting on/off) share one keypad model.
module tb_keypad_event_queue;
    logic        clk, RST, clr_ovf;
    logic [15:0] keys;
    logic [3:0]  col, col0, row, row0;
    logic [2:0]  count, count0;
    logic        overflow, overflow0, light, light0;
    int          checks = 0;
    int          failures = 0;

    keypad_event_queue_if #(.KW(4)) bus ();
    keypad_event_queue_if #(.KW(4)) bus0 ();

    keypad_event_queue #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_FRAMES(2),
                         .FIFO_DEPTH(4), .REPORT_REL(1)) dut (
        .clk(clk), .RST(RST), .col(col), .row(row), .ev(bus), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf), .light(light));

    keypad_event_queue #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_FRAMES(2),
                         .FIFO_DEPTH(4), .REPORT_REL(0)) dut0 (
        .clk(clk), .RST(RST), .col(col0), .row(row0), .ev(bus0), .count(count0),
        .overflow(overflow0), .clr_ovf(clr_ovf), .light(light0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a held key pulls its column low while its row is driven.
    always_comb begin
        col  = '1;
        col0 = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row[r])  col[c]  = 1'b0;
                if (keys[r*4+c] && !row0[r]) col0[c] = 1'b0;
            end
    end

    task automatic do_reset;
        @(negedge clk);
        RST = 1'b1; bus.out_ready = 1'b0; bus0.out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic test_reset;
        keys = '0;
        @(negedge clk);
        RST = 1'b1; bus.out_ready = 1'b0; bus0.out_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (row !== 4'b1110) begin failures++; $display("FAIL rst_row got=%b exp=1110", row); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        checks++; if (light !== 1'b0) begin failures++; $display("FAIL rst_light got=%b exp=0", light); end
        checks++; if (bus.out_code !== 4'd0 || bus.out_rel !== 1'b0) begin failures++; $display("FAIL rst_head got=%0d/%b exp=0/0", bus.out_code, bus.out_rel); end
        RST = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (row !== 4'b1101) begin failures++; $display("FAIL row_step got=%b exp=1101", row); end
        repeat (24) @(negedge clk);
        checks++; if (row !== 4'b1110) begin failures++; $display("FAIL row_wrap got=%b exp=1110", row); end
    endtask

    task automatic test_press;
        keys = '0;
        do_reset();
        keys[6] = 1'b1;
        repeat (96) @(negedge clk);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL press_count got=%0d exp=1", count); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL press_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_code !== 4'd6 || bus.out_rel !== 1'b0) begin failures++; $display("FAIL press_head got=%0d/%b exp=6/0", bus.out_code, bus.out_rel); end
        checks++; if (light !== 1'b1) begin failures++; $display("FAIL press_light got=%b exp=1", light); end
        checks++; if (count0 !== 3'd1) begin failures++; $display("FAIL press_count_norel got=%0d exp=1", count0); end
    endtask

    task automatic test_release;
        keys[6] = 1'b0;
        repeat (96) @(negedge clk);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL rel_count got=%0d exp=2", count); end
        checks++; if (light !== 1'b0) begin failures++; $display("FAIL rel_light got=%b exp=0", light); end
        checks++; if (count0 !== 3'd1) begin failures++; $display("FAIL rel_count_norel got=%0d exp=1", count0); end
        checks++; if (bus.out_code !== 4'd6 || bus.out_rel !== 1'b0) begin failures++; $display("FAIL rel_head0 got=%0d/%b exp=6/0", bus.out_code, bus.out_rel); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL pop1_count got=%0d exp=1", count); end
        checks++; if (bus.out_code !== 4'd6 || bus.out_rel !== 1'b1) begin failures++; $display("FAIL rel_head1 got=%0d/%b exp=6/1", bus.out_code, bus.out_rel); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL pop2 got=%b/%0d exp=0/0", bus.out_valid, count); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL pop_empty got=%0d exp=0", count); end
    endtask

    task automatic test_bounce;
        keys = '0;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            keys[6] = (f % 2 == 0);
            repeat (32) @(negedge clk);
        end
        keys = '0;
        repeat (64) @(negedge clk);
        checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL bounce got=%0d/%b exp=0/0", count, bus.out_valid); end
        checks++; if (light !== 1'b0) begin failures++; $display("FAIL bounce_light got=%b exp=0", light); end
    endtask

    task automatic test_same_row;
        keys = '0;
        keys[8] = 1'b1; keys[11] = 1'b1;
        do_reset();
        repeat (96) @(negedge clk);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL row_count got=%0d exp=2", count); end
        checks++; if (bus.out_code !== 4'd8 || bus.out_rel !== 1'b0) begin failures++; $display("FAIL row_first got=%0d/%b exp=8/0", bus.out_code, bus.out_rel); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.out_code !== 4'd11 || bus.out_rel !== 1'b0) begin failures++; $display("FAIL row_second got=%0d/%b exp=11/0", bus.out_code, bus.out_rel); end
        checks++; if (count0 !== 3'd2) begin failures++; $display("FAIL row_count_norel got=%0d exp=2", count0); end
    endtask

    task automatic test_overflow;
        int exp_codes[4] = '{0, 5, 6, 10};
        keys = '0;
        keys[0] = 1'b1; keys[5] = 1'b1; keys[6] = 1'b1; keys[10] = 1'b1; keys[15] = 1'b1;
        do_reset();
        repeat (96) @(negedge clk);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        keys = '0;
        repeat (96) @(negedge clk);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_full got=%0d exp=4", count); end
        checks++; if (count0 !== 3'd4 || overflow0 !== 1'b1) begin failures++; $display("FAIL ovf_norel got=%0d/%b exp=4/1", count0, overflow0); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_code) != exp_codes[i] || bus.out_rel !== 1'b0) begin
                failures++;
                $display("FAIL drain%0d got=%b/%0d/%b exp=1/%0d/0", i, bus.out_valid, bus.out_code, bus.out_rel, exp_codes[i]);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        checks++; if (count !== 3'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, bus.out_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    initial begin
        RST = 1'b1; clr_ovf = 1'b0; keys = '0;
        bus.out_ready = 1'b0; bus0.out_ready = 1'b0;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_same_row();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
